bsg_wormhole_link_wrr_arbiter: RTL and testbench
================================================

BSG_WORMHOLE_LINK_WRR_ARBITER -- requirements
Module: bsg_wormhole_link_wrr_arbiter

Interface
REQ-001 SHALL have parameter num_in_p, default 4: number of requester wormhole links sharing one output link (>=2).
REQ-002 SHALL have parameter flit_width_p, default 32: flit width in bits.
REQ-003 SHALL have parameter len_width_p, default 4: width of the header length field (number of body flits).
REQ-004 SHALL have parameter len_offset_p, default 8: bit position of the header length field LSB (above cord+cid).
REQ-005 SHALL have parameter weight_width_p, default 2: width of per-input packet weight.
REQ-006 clk_i  input  1  single clock; all state on rising edge.
REQ-007 reset_n_i  input  1  asynchronous, active-low reset.
REQ-008 weights_i  input  num_in_p*weight_width_p  max consecutive packets per grant, per input; sampled at grant start.
REQ-009 in_v_i  input  num_in_p  requester flit valid.
REQ-010 in_data_i  input  num_in_p*flit_width_p  requester flit data.
REQ-011 in_ready_o  output  num_in_p  requester flit accepted when in_v_i & in_ready_o.
REQ-012 out_v_o  output  1  output flit valid.
REQ-013 out_data_o  output  flit_width_p  output flit data.
REQ-014 out_ready_i  input  1  downstream ready; flit transfers on out_v_o & out_ready_i.
REQ-015 grant_o  output  num_in_p  one-hot owner of the output; zero when no owner.
REQ-016 busy_o  output  1  high while a packet body is in flight (state BODY).

Function
REQ-017 SHALL implement states IDLE (no packet open) and BODY (packet open, body flits remaining).
REQ-018 In IDLE, SHALL select the first valid input at or after rr_ptr (wrapping modulo num_in_p), unless a weight credit holds the previous winner (REQ-024); selection is combinational, zero-cycle latency.
REQ-019 SHALL drive out_v_o = in_v_i[sel], out_data_o = in_data_i[sel], in_ready_o[sel] = out_ready_i; all other in_ready_o bits 0.
REQ-020 On header transfer with len field L>0: SHALL load len_cnt = L, lock sel, go to BODY.
REQ-021 On header transfer with L=0: packet complete that cycle; SHALL remain IDLE and apply end-of-packet update (REQ-023).
REQ-022 In BODY, SHALL forward only the locked input regardless of other valids; decrement len_cnt per transferred flit; on transfer with len_cnt=1 return to IDLE and apply end-of-packet update.
REQ-023 End-of-packet: credit decremented; if credit reaches 0, rr_ptr = (sel+1) mod num_in_p and credit cleared.
REQ-024 If credit >0 and the previous winner has in_v_i high in IDLE, SHALL re-grant it; if it is not valid, SHALL forfeit credit and arbitrate normally from (sel+1).
REQ-025 On new grant to a different input, credit SHALL load max(weights_i[sel],1) minus 1 after that packet; weight 0 behaves as 1.
REQ-026 out_v_o low with out_ready_i high, or out_ready_i low, SHALL not change len_cnt, state, pointer or credit.
REQ-027 grant_o SHALL equal one-hot(sel) whenever out_v_o is high or state is BODY; 0 otherwise.
REQ-028 out_data_o SHALL be don't-care but stable-from-source when out_v_o low; no internal data buffering.
REQ-029 len_cnt SHALL be len_width_p bits; maximum packet 2^len_width_p flits total.

Reset
REQ-030 On reset_n_i low, SHALL asynchronously force state=IDLE, rr_ptr=0, credit=0, len_cnt=0; out_v_o, in_ready_o, grant_o, busy_o then follow IDLE rules with all inputs considered (outputs 0 while in_v_i=0).
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts from input 0 and the next flit seen is treated as a header.
REQ-032 Reset release SHALL be synchronized by the integrator; block assumes deassertion synchronous to clk_i.

Verification
REQ-033 All inputs valid, L=0, weights=1, out_ready_i=1 -> grants cycle 0,1,2,3,0 on consecutive cycles.
REQ-034 Input 1 sends header L=3 while input 0 valid -> four consecutive flits from input 1, busy_o high 3 cycles, grant_o=0010 throughout, input 0 in_ready_o=0.
REQ-035 weights_i[2]=3, input 2 streams L=0 packets, others valid -> input 2 wins 3 consecutive packets, then input 3.
REQ-036 out_ready_i toggled 0/1 during an L=2 packet -> exactly 3 transfers, no flit lost or duplicated, len_cnt frozen on stall cycles.
REQ-037 reset_n_i pulsed low during BODY with len_cnt=2 -> busy_o=0 immediately, next grant to lowest valid index from 0.
REQ-038 Credit holder deasserts valid after first of weight 3 -> next grant to next valid index; credit forfeited.

Source files
------------

// File: rtl/bsg_wormhole_link_wrr_arbiter.sv
// bsg_wormhole_link_wrr_arbiter: weighted round-robin arbiter merging wormhole links onto one output
module bsg_wormhole_link_wrr_arbiter #(
    parameter int num_in_p       = 4,
    parameter int flit_width_p   = 32,
    parameter int len_width_p    = 4,
    parameter int len_offset_p   = 8,
    parameter int weight_width_p = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [num_in_p*weight_width_p-1:0] weights_i,
    input  logic [num_in_p-1:0]                in_v_i,
    input  logic [num_in_p*flit_width_p-1:0]   in_data_i,
    output logic [num_in_p-1:0]                in_ready_o,
    output logic                               out_v_o,
    output logic [flit_width_p-1:0]            out_data_o,
    input  logic                               out_ready_i,
    output logic [num_in_p-1:0]                grant_o,
    output logic                               busy_o
);
    localparam int SW = (num_in_p > 1) ? $clog2(num_in_p) : 1;
    localparam logic [SW-1:0] LAST = SW'(num_in_p - 1);

    typedef enum logic {IDLE, BODY} state_t;

    state_t                    r_state, w_next;
    logic [SW-1:0]             r_ptr, r_sel, w_last, w_off, w_srch, w_sel, w_sel_inc;
    logic [SW:0]               w_sum;
    logic [num_in_p-1:0]       w_rot;
    logic [weight_width_p-1:0] r_credit, w_weight, w_credit;
    logic [len_width_p-1:0]    r_len, w_hdr_len;
    logic                      w_hold, w_xfer;

    // the pointer always sits one past the previous winner, so the winner is recoverable from it
    assign w_last    = (r_ptr == '0) ? LAST : r_ptr - SW'(1);
    assign w_hold    = (r_credit != '0) && in_v_i[w_last];
    assign w_rot     = num_in_p'({in_v_i, in_v_i} >> r_ptr);
    assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_srch    = (w_sum >= (SW+1)'(num_in_p)) ? SW'(w_sum - (SW+1)'(num_in_p)) : SW'(w_sum);
    assign w_sel     = (r_state == BODY) ? r_sel : w_hold ? w_last : w_srch;
    assign w_sel_inc = (w_sel == LAST) ? '0 : w_sel + SW'(1);
    assign w_hdr_len = in_data_i[w_sel*flit_width_p + len_offset_p +: len_width_p];
    assign w_weight  = weights_i[w_sel*weight_width_p +: weight_width_p];
    // credit left after this packet: held winners spend one, fresh winners start from their weight
    assign w_credit  = w_hold ? r_credit - weight_width_p'(1)
                              : (w_weight == '0) ? '0 : w_weight - weight_width_p'(1);
    assign w_xfer    = out_v_o & out_ready_i;

    // offset of the first valid requester at or after the pointer
    always_comb begin
        w_off = '0;
        for (int i = num_in_p - 1; i >= 0; i--)
            if (w_rot[i]) w_off = SW'(i);
    end

    // state register
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_next;
    end

    // a header with body flits opens a packet; the last body flit closes it
    always_comb begin
        w_next = !w_xfer ? r_state
               : (r_state == IDLE) ? ((w_hdr_len != '0) ? BODY : IDLE)
               : ((r_len == len_width_p'(1)) ? IDLE : BODY);
    end

    // output mux: only the selected input sees downstream ready
    always_comb begin
        out_v_o    = in_v_i[w_sel];
        out_data_o = in_data_i[w_sel*flit_width_p +: flit_width_p];
        busy_o     = (r_state == BODY);
        in_ready_o = '0;
        grant_o    = '0;
        if (out_v_o || busy_o) begin
            in_ready_o[w_sel] = out_ready_i;
            grant_o[w_sel]    = 1'b1;
        end
    end

    // pointer, credit and winner settle on the header; body flits only count down
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ptr    <= '0;
            r_sel    <= '0;
            r_credit <= '0;
            r_len    <= '0;
        end else if (w_xfer && r_state == IDLE) begin
            r_ptr    <= w_sel_inc;
            r_sel    <= w_sel;
            r_credit <= w_credit;
            r_len    <= w_hdr_len;
        end else if (w_xfer) begin
            r_len    <= r_len - len_width_p'(1);
        end
    end
endmodule

// File: tb/tb_bsg_wormhole_link_wrr_arbiter.sv
// tb_bsg_wormhole_link_wrr_arbiter: randomized check of the wrr wormhole arbiter against a packet-level model
module tb_bsg_wormhole_link_wrr_arbiter;
    localparam int N = 4, F = 32, LW = 4, LO = 8, WW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N*WW-1:0]   weights;
    logic [N-1:0]      in_v, in_ready, grant;
    logic [N*F-1:0]    in_data;
    logic              out_v, out_ready, busy;
    logic [F-1:0]      out_data;

    int n_chk = 0, n_err = 0;
    int m_owner, m_left, m_ptr, m_last, m_credit, m_wsamp;
    bit m_new;

    bsg_wormhole_link_wrr_arbiter #(
        .num_in_p(N), .flit_width_p(F), .len_width_p(LW), .len_offset_p(LO), .weight_width_p(WW)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .weights_i(weights), .in_v_i(in_v), .in_data_i(in_data),
        .in_ready_o(in_ready), .out_v_o(out_v), .out_data_o(out_data), .out_ready_i(out_ready),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_ptr = 0; m_last = 0; m_credit = 0; m_wsamp = 1; m_new = 1'b1;
    endtask

    // winner per the arbitration rules, -1 when nobody can be chosen
    function automatic int model_sel();
        int start;
        if (m_owner >= 0) return m_owner;
        if (m_credit > 0 && in_v[m_last]) return m_last;
        start = (m_credit > 0) ? (m_last + 1) % N : m_ptr;
        for (int k = 0; k < N; k++)
            if (in_v[(start + k) % N]) return (start + k) % N;
        return -1;
    endfunction

    task automatic end_of_packet(input int s);
        m_credit = m_new ? m_wsamp - 1 : m_credit - 1;
        m_last = s;
        if (m_credit == 0) m_ptr = (s + 1) % N;
    endtask

    // compare all outputs with the model, then advance the model across the coming edge
    task automatic check_and_step();
        int s, len, w;
        bit act, ev;
        logic [N-1:0] eg, er;
        s   = model_sel();
        ev  = (s >= 0) && in_v[s];
        act = (s >= 0) && (ev || m_owner >= 0);
        eg  = act ? N'(1) << s : '0;
        er  = (act && out_ready) ? N'(1) << s : '0;
        chk("out_v", out_v, ev);
        chk("grant", grant, eg);
        chk("in_ready", in_ready, er);
        chk("busy", busy, m_owner >= 0);
        if (ev) chk("out_data", out_data, in_data[s*F +: F]);
        if (ev && out_ready) begin
            if (m_owner < 0) begin
                len   = int'(in_data[s*F + LO +: LW]);
                m_new = !(m_credit > 0 && in_v[m_last]);
                w     = int'(weights[s*WW +: WW]);
                if (m_new) m_wsamp = (w == 0) ? 1 : w;
                if (len > 0) begin m_owner = s; m_left = len; end
                else end_of_packet(s);
            end else begin
                m_left--;
                if (m_left == 0) begin m_owner = -1; end_of_packet(s); end
            end
        end
    endtask

    function automatic logic [F-1:0] flit(input int len);
        logic [F-1:0] d;
        d = $urandom;
        d[LO +: LW] = LW'(len);
        return d;
    endfunction

    logic [N-1:0] exp33 [5];
    logic [N-1:0] r33;

    initial begin
        model_reset();
        reset_n = 1'b0; in_v = '0; in_data = '0; out_ready = 1'b1; weights = '0;
        #3;
        chk("rst_out_v", out_v, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1 reset_n = 1'b1;

        // all valid, zero-length packets, unit weights: plain rotation
        exp33 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        weights = {N{2'd1}}; in_v = '1; in_data = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            r33 = exp33[c];
            chk("rotate", grant, r33);
            check_and_step();
            @(posedge clk); #1;
        end

        // input 1 sends a three-body packet while input 0 competes
        in_v = 4'b0011;
        in_data[0 +: F] = flit(0);
        in_data[F +: F] = flit(3);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("lock_grant", grant, 4'b0010);
            chk("lock_busy", busy, c != 0);
            chk("lock_rdy0", in_ready[0], 0);
            check_and_step();
            @(posedge clk); #1;
            in_data[F +: F] = flit(c);
        end

        // randomized traffic, stalls, weights and occasional asynchronous reset
        for (int c = 0; c < 4000; c++) begin
            in_v      = N'($urandom);
            if ($urandom_range(0, 3) != 0) in_v = in_v | N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            weights   = (N*WW)'($urandom);
            for (int i = 0; i < N; i++)
                in_data[i*F +: F] = flit(($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                #1;
                model_reset();
                chk("async_rst_busy", busy, 0);
                #1 reset_n = 1'b1;
            end
            @(negedge clk);
            check_and_step();
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
